// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single-port synchronous memory.
// Each access takes IDLE -> ACCESS -> RESP, so a request completes two cycles after it is granted.
//   state  | meaning
//   IDLE   | waiting for a request; a grant latches the winner's command
//   ACCESS | drive the memory from the latched command; capture read data
//   RESP   | pulse the winner's ack for one cycle
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [15:0] mem_address,
  output logic        mem_load,
  output logic        mem_out_en,
  output logic [15:0] mem_data_out,
  input  logic [15:0] mem_data_in
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        win_q, win_d;
  logic        last_q, last_d;
  logic        winner;

  // On a tie the requester not granted last wins.
  always_comb begin
    winner = req1;
    if (req0 && req1) winner = ~last_q;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    win_d   = win_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACCESS;
          win_d   = winner;
          last_d  = winner;
          we_d    = winner ? we1    : we0;
          addr_d  = winner ? addr1  : addr0;
          wdata_d = winner ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!we_q) rdata_d = mem_data_in;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      win_q   <= win_d;
      last_q  <= last_d;
    end
  end

  // addr_q only changes on a grant, so the memory address holds between accesses.
  assign mem_address  = addr_q;
  assign mem_load     = (state_q == ACCESS) &&  we_q;
  assign mem_out_en   = (state_q == ACCESS) && !we_q;
  assign mem_data_out = mem_load ? wdata_q : 16'hzzzz;
  assign ack0         = (state_q == RESP) && !win_q;
  assign ack1         = (state_q == RESP) &&  win_q;
  assign rdata        = rdata_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory attached.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, busy, mem_load, mem_out_en;
  logic [15:0] rdata, mem_address, mem_data_out, mem_data_in;

  int n_vec = 0;
  int n_err = 0;
  bit done  = 1'b0;

  logic [15:0] mem [0:255];

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_address(mem_address), .mem_load(mem_load), .mem_out_en(mem_out_en),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_load) mem[mem_address[7:0]] <= mem_data_out;
  assign mem_data_in = mem_out_en ? mem[mem_address[7:0]] : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && !done) begin
      chk("inv_load_oen", {31'd0, mem_load & mem_out_en}, 32'd0);
      chk("inv_acks",     {31'd0, ack0 & ack1}, 32'd0);
      chk("inv_busy",     {31'd0, busy}, {31'd0, mem_load | mem_out_en | ack0 | ack1});
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_acks"},  {30'd0, ack1, ack0}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_strb"},  {30'd0, mem_load, mem_out_en}, 32'd0);
    chk({tag, "_addr"},  {16'd0, mem_address}, 32'h0000);
    chk({tag, "_rdata"}, {16'd0, rdata}, 32'h0000);
  endtask

  task automatic drive(input bit who, input bit we, input logic [15:0] a, input logic [15:0] d);
    if (who) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else     begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  task automatic single(input bit who, input bit we, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] rexp);
    drive(who, we, a, d);
    tick();
    chk("acc_load", {31'd0, mem_load},   {31'd0, we});
    chk("acc_oen",  {31'd0, mem_out_en}, {31'd0, !we});
    chk("acc_addr", {16'd0, mem_address}, {16'd0, a});
    if (we) chk("acc_wdata", {16'd0, mem_data_out}, {16'd0, d});
    chk("acc_noack", {30'd0, ack1, ack0}, 32'd0);
    tick();
    chk("resp_ack",  {30'd0, ack1, ack0}, who ? 32'd2 : 32'd1);
    chk("resp_strb", {30'd0, mem_load, mem_out_en}, 32'd0);
    chk("resp_addr", {16'd0, mem_address}, {16'd0, a});
    if (!we) chk("resp_rdata", {16'd0, rdata}, {16'd0, rexp});
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_ack",  {30'd0, ack1, ack0}, 32'd0);
    chk("idle_addr", {16'd0, mem_address}, {16'd0, a});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    reset = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    #2;
    check_reset_outputs("rst");
    #10;
    reset = 1'b1;

    // Write then read back through the CPU port, then the loader path.
    single(1'b0, 1'b1, 16'h0000, 16'h5A5A, 16'h0000);
    single(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h5A5A);
    single(1'b1, 1'b1, 16'h0010, 16'hA5A5, 16'h0000);
    single(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5);

    // Fresh reset so requester 0 wins the first tie; both saturate.
    reset = 1'b0;
    #1;
    check_reset_outputs("rst2");
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b1, 16'h0020, 16'h1111);
    drive(1'b1, 1'b1, 16'h0030, 16'h2222);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tie_addr", {16'd0, mem_address}, (i % 2 == 1) ? 32'h0030 : 32'h0020);
      chk("tie_load", {31'd0, mem_load}, 32'd1);
      chk("tie_data", {16'd0, mem_data_out}, (i % 2 == 1) ? 32'h2222 : 32'h1111);
      tick();
      chk("tie_ack", {30'd0, ack1, ack0}, (i % 2 == 1) ? 32'd2 : 32'd1);
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
      chk("tie_gap", {31'd0, busy}, 32'd0);
    end
    tick();
    chk("tie_end", {31'd0, busy}, 32'd0);
    chk("tie_mem0", {16'd0, mem[8'h20]}, 32'h1111);
    chk("tie_mem1", {16'd0, mem[8'h30]}, 32'h2222);

    // Address changes mid-access must be ignored.
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    addr0 = 16'h0010;
    #1;
    chk("chg_addr", {16'd0, mem_address}, 32'h0000);
    tick();
    chk("chg_ack",   {30'd0, ack1, ack0}, 32'd1);
    chk("chg_rdata", {16'd0, rdata}, 32'h5A5A);
    req0 = 1'b0;
    tick();

    // Reset during a write access aborts it.
    drive(1'b0, 1'b1, 16'h0040, 16'hBEEF);
    tick();
    chk("abort_pre", {31'd0, mem_load}, 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    req0 = 1'b0;
    tick();
    check_reset_outputs("abort_hold");
    reset = 1'b1;
    chk("abort_mem", {16'd0, mem[8'h40]}, 32'h0000);
    single(1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000);
    single(1'b1, 1'b1, 16'h0050, 16'hCAFE, 16'h0000);
    single(1'b0, 1'b0, 16'h0050, 16'h0000, 16'hCAFE);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
